// File: rtl/fifo_wr_arbiter.sv
// Packet-locked round-robin arbiter sharing one FIFO write port between N_REQ
// parser channels; a grant is held until the owner's last word (or MAX_PKT words).
module fifo_wr_arbiter #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned MAX_PKT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    input  logic [N_REQ-1:0]       last,
    output logic [N_REQ-1:0]       ready,
    output logic [WIDTH-1:0]       fifo_wdata,
    output logic                   fifo_wr_en,
    input  logic                   fifo_full,
    output logic [N_REQ-1:0]       gnt,
    output logic                   err_trunc,
    output logic [15:0]            pkt_cnt
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = (MAX_PKT > 1) ? $clog2(MAX_PKT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_PKT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REQ - 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [N_REQ-1:0]   gnt_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               err_d;
    logic [15:0]        pkt_cnt_d;

    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    int unsigned        cand;
    logic               xfer_c;

    // First requesting channel at or above the round-robin pointer, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = 32'(rr_q) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
    end

    // Write-port steering from the locked owner.
    always_comb begin
        fifo_wdata = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (owner_q == IDX_W'(i)) begin
                fifo_wdata = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    assign xfer_c     = (state_q == BUSY) && req[owner_q] && !fifo_full;
    assign fifo_wr_en = xfer_c;
    assign ready      = ((state_q == BUSY) && !fifo_full) ? gnt : '0;

    // Next-state logic: arbitrate when idle, track the packet while busy.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        owner_d   = owner_q;
        rr_d      = rr_q;
        count_d   = count_q;
        err_d     = 1'b0;
        pkt_cnt_d = pkt_cnt;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    state_d = BUSY;
                    owner_d = win_idx;
                    gnt_d   = N_REQ'(1) << win_idx;
                    count_d = '0;
                end
            end
            BUSY: begin
                if (xfer_c) begin
                    if (last[owner_q] || (count_q == CNT_LAST)) begin
                        state_d   = IDLE;
                        gnt_d     = '0;
                        pkt_cnt_d = pkt_cnt + 16'd1;
                        rr_d      = (owner_q == IDX_LAST) ? '0 : owner_q + 1'b1;
                        err_d     = !last[owner_q];
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            gnt       <= '0;
            owner_q   <= '0;
            rr_q      <= '0;
            count_q   <= '0;
            err_trunc <= 1'b0;
            pkt_cnt   <= '0;
        end else begin
            state_q   <= state_d;
            gnt       <= gnt_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            count_q   <= count_d;
            err_trunc <= err_d;
            pkt_cnt   <= pkt_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized scoreboard bench for fifo_wr_arbiter: channel packet sources, a
// packet-level reference model, and a monitor comparing every cycle and write.
module tb_fifo_wr_arbiter;

    localparam int unsigned W    = 32;
    localparam int unsigned N    = 4;
    localparam int unsigned MAXP = 4;
    localparam int unsigned NCYC = 4000;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req, last, ready, gnt;
    logic [N*W-1:0]  wdata;
    logic [W-1:0]    fifo_wdata;
    logic            fifo_wr_en, fifo_full, err_trunc;
    logic [15:0]     pkt_cnt;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.WIDTH(W), .N_REQ(N), .MAX_PKT(MAXP)) dut (
        .clk(clk), .rst(rst), .req(req), .wdata(wdata), .last(last),
        .ready(ready), .fifo_wdata(fifo_wdata), .fifo_wr_en(fifo_wr_en),
        .fifo_full(fifo_full), .gnt(gnt), .err_trunc(err_trunc), .pkt_cnt(pkt_cnt)
    );

    typedef struct packed {
        logic [N-1:0] gnt;
        logic [N-1:0] ready;
        logic         wr_en;
        logic         err;
        logic [15:0]  pkt;
    } exp_t;

    exp_t        exp_cyc[$];
    logic [W-1:0] exp_wr[$];
    logic [W:0]  src_q[N][$];
    int          pkt_id[N];
    int          checks = 0;
    int          failures = 0;
    int          full_burst = 0;

    // Reference model state: owner channel (-1 when none) and packet bookkeeping.
    bit          m_known = 0;
    int          m_owner, m_ptr, m_cnt;
    logic [15:0] m_pkt;
    bit          m_err;

    task automatic refill();
        int len;
        for (int ch = 0; ch < N; ch++) begin
            if (src_q[ch].size() == 0 && $urandom_range(0, 3) == 0) begin
                len = $urandom_range(1, 6);
                for (int k = 0; k < len; k++) begin
                    src_q[ch].push_back({(k == len - 1), 8'(ch), 8'(pkt_id[ch]), 16'(k)});
                end
                pkt_id[ch]++;
            end
        end
    endtask

    task automatic do_cycle(input logic rst_v, input bit force_all);
        logic [N-1:0]   rq, ls;
        logic [N*W-1:0] wd;
        logic [W:0]     head;
        bit             fl, xf, found;
        int             c;
        exp_t           e;
        @(posedge clk);
        #1;
        refill();
        if (full_burst > 0) begin
            fl = 1'b1;
            full_burst--;
        end else if ($urandom_range(0, 99) < 3) begin
            fl = 1'b1;
            full_burst = 4;
        end else begin
            fl = ($urandom_range(0, 99) < 15);
        end
        for (int ch = 0; ch < N; ch++) begin
            if (src_q[ch].size() > 0) begin
                head = src_q[ch][0];
                rq[ch] = ($urandom_range(0, 99) < 85);
                wd[ch*W +: W] = head[W-1:0];
                ls[ch] = head[W];
            end else begin
                rq[ch] = 1'b0;
                wd[ch*W +: W] = $urandom;
                ls[ch] = 1'($urandom_range(0, 1));
            end
            if (force_all) rq[ch] = 1'b1;
        end
        rst = rst_v; req = rq; last = ls; wdata = wd; fifo_full = fl;

        xf = 0;
        if (m_known) begin
            xf = (m_owner >= 0) && rq[m_owner] && !fl;
            e.gnt   = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
            e.ready = ((m_owner >= 0) && !fl) ? e.gnt : '0;
            e.wr_en = xf;
            e.err   = m_err;
            e.pkt   = m_pkt;
            exp_cyc.push_back(e);
            if (xf) begin
                exp_wr.push_back(wd[m_owner*W +: W]);
                if (src_q[m_owner].size() > 0) void'(src_q[m_owner].pop_front());
            end
        end

        // Model update for the coming clock edge.
        if (!rst_v) begin
            m_known = 1; m_owner = -1; m_ptr = 0; m_cnt = 0; m_pkt = '0; m_err = 0;
        end else if (m_known) begin
            m_err = 0;
            if (m_owner < 0) begin
                found = 0;
                for (int k = 0; k < N; k++) begin
                    c = (m_ptr + k) % N;
                    if (!found && rq[c]) begin
                        found = 1; m_owner = c; m_cnt = 0;
                    end
                end
            end else if (xf) begin
                if (ls[m_owner] || m_cnt == MAXP - 1) begin
                    m_err   = !ls[m_owner];
                    m_pkt   = m_pkt + 16'd1;
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = -1;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    // Monitor: compare registered/combinational state every cycle and every write.
    always @(negedge clk) begin
        exp_t e;
        logic [W-1:0] w;
        if (exp_cyc.size() > 0) begin
            e = exp_cyc.pop_front();
            checks++;
            if ({gnt, ready, fifo_wr_en, err_trunc, pkt_cnt} !== e) begin
                failures++;
                $display("FAIL cycle_state @%0t actual gnt=%b ready=%b wr_en=%b err=%b pkt=%0d required gnt=%b ready=%b wr_en=%b err=%b pkt=%0d",
                         $time, gnt, ready, fifo_wr_en, err_trunc, pkt_cnt,
                         e.gnt, e.ready, e.wr_en, e.err, e.pkt);
            end
        end
        if (fifo_wr_en === 1'b1) begin
            checks++;
            if (exp_wr.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write @%0t actual data=%h required none", $time, fifo_wdata);
            end else begin
                w = exp_wr.pop_front();
                if (fifo_wdata !== w) begin
                    failures++;
                    $display("FAIL write_data @%0t actual=%h required=%h", $time, fifo_wdata, w);
                end
            end
        end
    end

    initial begin
        rst = 1'b0; req = '0; last = '0; wdata = '0; fifo_full = 1'b0;
        for (int ch = 0; ch < N; ch++) pkt_id[ch] = 0;
        do_cycle(1'b0, 1'b1);
        do_cycle(1'b0, 1'b1);
        for (int n = 0; n < 200; n++) do_cycle(1'b1, 1'b1);
        for (int n = 0; n < NCYC; n++) begin
            do_cycle(($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1, 1'b0);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (exp_wr.size() != 0 || exp_cyc.size() != 0) begin
            failures++;
            $display("FAIL leftover_expected actual writes_left=%0d cycles_left=%0d required 0",
                     exp_wr.size(), exp_cyc.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
